// File: rtl/link_tx_scheduler_pkg.sv
// Shared definitions for the link TX scheduler: frame geometry, idle tag and FSM states.
package link_pkg;

  localparam int unsigned DATA_SIZE = 194;
  localparam int unsigned TAG_W     = 2;
  localparam int unsigned PAYLOAD_W = DATA_SIZE - TAG_W;

  localparam logic [TAG_W-1:0] TAG_IDLE = '0;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    WAIT_DONE
  } sched_state_t;

endpackage

// File: rtl/link_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any_req
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant   = '0;
    o_winner  = '0;
    o_any_req = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_any_req && i_req[w_idx]) begin
        o_any_req       = 1'b1;
        o_grant[w_idx]  = 1'b1;
        o_winner        = w_idx;
      end
    end
  end

endmodule

// File: rtl/link_tx_scheduler.sv
// Round-robin sharing of the outbound serial frame link with tag insertion and done timeout.
// Optional keep-alive (tag-0) frames after IDLE_GAP idle cycles: define LINK_IDLE_FRAME_EN.
module link_tx_scheduler
  import link_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned DONE_TIMEOUT = 1024,
  parameter int unsigned IDLE_GAP     = 4096
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_SIZE-1:0]         frm_data,
  output logic                         frm_valid,
  input  logic                         frm_ready,
  input  logic                         frm_done,
  output logic                         busy,
  output logic [15:0]                  frames_sent,
  output logic                         err_timeout
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TO_W  = $clog2(DONE_TIMEOUT);

  if (NUM_REQ < 1 || NUM_REQ > (2**TAG_W) - 1) begin : g_bad_num_req
    $error("NUM_REQ does not fit the non-idle tag space");
  end
  if (DONE_TIMEOUT < 2 || IDLE_GAP < 2) begin : g_bad_timing
    $error("DONE_TIMEOUT and IDLE_GAP must be at least 2");
  end

  sched_state_t r_state, w_state_nxt;

  logic [IDX_W-1:0]     r_rr_ptr;
  logic [TO_W-1:0]      r_to_cnt;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [DATA_SIZE-1:0] r_frm_data;
  logic                 r_frm_valid;
  logic [15:0]          r_frames_sent;
  logic                 r_err_timeout;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]     w_winner;
  logic                 w_any_req;
  logic [PAYLOAD_W-1:0] w_payload;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_load_req;
  logic                 w_load_idle;
  logic                 w_handoff;
  logic                 w_finish;
  logic                 w_timeout;
  logic                 w_count;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .o_grant   (w_grant),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  always_comb begin
    w_payload = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_payload = req_data[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  assign w_tag = TAG_W'(w_winner) + TAG_W'(1);

`ifdef LINK_IDLE_FRAME_EN
  localparam int unsigned IG_W = $clog2(IDLE_GAP);

  logic            r_keepalive;
  logic [IG_W-1:0] r_idle_cnt;
  logic            w_gap_hit;

  assign w_gap_hit = (r_idle_cnt == IG_W'(IDLE_GAP - 1));
  assign w_count   = w_finish && !r_keepalive;

  // Counts consecutive request-free IDLE cycles; any grant restarts it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_idle_cnt  <= '0;
      r_keepalive <= 1'b0;
    end else begin
      if (r_state == IDLE && !w_any_req && !w_gap_hit) r_idle_cnt <= r_idle_cnt + IG_W'(1);
      else                                              r_idle_cnt <= '0;
      if (w_load_req)       r_keepalive <= 1'b0;
      else if (w_load_idle) r_keepalive <= 1'b1;
    end
  end
`else
  assign w_count = w_finish;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load_req  = 1'b0;
    w_load_idle = 1'b0;
    w_handoff   = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_load_req  = 1'b1;
          w_state_nxt = OFFER;
        end
`ifdef LINK_IDLE_FRAME_EN
        else if (w_gap_hit) begin
          w_load_idle = 1'b1;
          w_state_nxt = OFFER;
        end
`endif
      end
      OFFER: begin
        if (frm_ready) begin
          w_handoff   = 1'b1;
          w_state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (frm_done) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_to_cnt == TO_W'(DONE_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_to_cnt      <= '0;
      r_req_ready   <= '0;
      r_frm_data    <= '0;
      r_frm_valid   <= 1'b0;
      r_frames_sent <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= '0;
      if (w_load_req) begin
        r_req_ready <= w_grant;
        r_frm_data  <= {w_tag, w_payload};
        r_frm_valid <= 1'b1;
        r_rr_ptr    <= (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + IDX_W'(1);
      end else if (w_load_idle) begin
        r_frm_data  <= {TAG_IDLE, {PAYLOAD_W{1'b0}}};
        r_frm_valid <= 1'b1;
      end
      if (w_handoff) begin
        r_frm_valid <= 1'b0;
        r_to_cnt    <= '0;
      end else if (r_state == WAIT_DONE) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_count)   r_frames_sent <= r_frames_sent + 16'd1;
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign req_ready   = r_req_ready;
  assign frm_data    = r_frm_data;
  assign frm_valid   = r_frm_valid;
  assign busy        = (r_state != IDLE);
  assign frames_sent = r_frames_sent;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Directed + randomized bench for link_tx_scheduler with a round-robin reference model.
module tb_link_tx_scheduler;
  import link_pkg::*;

  localparam int unsigned NREQ = 3;
  localparam int unsigned TMO  = 1024;
  localparam int unsigned GAP  = 16;
  localparam int unsigned W    = DATA_SIZE;

  logic                      CLK = 1'b0;
  logic                      RESET;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ*PAYLOAD_W-1:0] req_data;
  logic [NREQ-1:0]           req_ready;
  logic [DATA_SIZE-1:0]      frm_data;
  logic                      frm_valid;
  logic                      frm_ready;
  logic                      frm_done;
  logic                      busy;
  logic [15:0]               frames_sent;
  logic                      err_timeout;

  link_tx_scheduler #(
    .NUM_REQ      (NREQ),
    .DONE_TIMEOUT (TMO),
    .IDLE_GAP     (GAP)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .frm_data    (frm_data),
    .frm_valid   (frm_valid),
    .frm_ready   (frm_ready),
    .frm_done    (frm_done),
    .busy        (busy),
    .frames_sent (frames_sent),
    .err_timeout (err_timeout)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                   ptr;
  int                   frames;
  logic                 err;
  logic [NREQ-1:0]      cur;
  logic [PAYLOAD_W-1:0] pay [NREQ];
  logic [W-1:0]         exp_frame;
  int                   w;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] rand_payload();
    logic [PAYLOAD_W-1:0] p;
    for (int i = 0; i < PAYLOAD_W / 32; i++) p[i*32 +: 32] = $urandom();
    return p;
  endfunction

  task automatic drive_reqs();
    req_valid = cur;
    for (int i = 0; i < NREQ; i++) req_data[i*PAYLOAD_W +: PAYLOAD_W] = pay[i];
  endtask

  // Newly raised requesters get fresh payloads; already-pending ones keep theirs.
  task automatic raise(input logic [NREQ-1:0] m);
    for (int i = 0; i < NREQ; i++) begin
      if (m[i] && !cur[i]) begin
        pay[i] = rand_payload();
        cur[i] = 1'b1;
      end
    end
    drive_reqs();
  endtask

  task automatic grant_phase(output int win);
    win = rr_pick(ptr, cur);
    @(negedge CLK);
    exp_frame = {TAG_W'(win + 1), pay[win]};
    check("grant_ready", W'(req_ready), W'(1) << win);
    check("grant_valid", W'(frm_valid), W'(1));
    check("grant_frame", frm_data, exp_frame);
    check("grant_busy", W'(busy), W'(1));
    ptr = (win + 1) % NREQ;
    cur[win] = 1'b0;
    drive_reqs();
  endtask

  task automatic offer_phase(input int rdy);
    for (int i = 0; i < rdy; i++) begin
      frm_done = (i == 0);
      @(negedge CLK);
      frm_done = 1'b0;
      check("offer_valid", W'(frm_valid), W'(1));
      check("offer_frame", frm_data, exp_frame);
      check("offer_ready", W'(req_ready), W'(0));
    end
    if (rdy > 0) check("offer_stray_done", W'(frames_sent), W'(16'(frames)));
    frm_ready = 1'b1;
    @(negedge CLK);
    frm_ready = 1'b0;
    check("handoff_valid", W'(frm_valid), W'(0));
    check("handoff_busy", W'(busy), W'(1));
  endtask

  task automatic done_phase(input int dn);
    for (int i = 0; i < dn; i++) begin
      @(negedge CLK);
      check("wait_busy", W'(busy), W'(1));
      check("wait_ready", W'(req_ready), W'(0));
    end
    frm_done = 1'b1;
    @(negedge CLK);
    frm_done = 1'b0;
    frames = (frames + 1) % 65536;
    check("done_count", W'(frames_sent), W'(16'(frames)));
    check("done_busy", W'(busy), W'(0));
    check("done_ready", W'(req_ready), W'(0));
    check("done_err", W'(err_timeout), W'(err));
  endtask

  task automatic send_frame(input int rdy, input int dn);
    grant_phase(w);
    offer_phase(rdy);
    done_phase(dn);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, W'(req_ready), W'(0));
    check({tag, "_valid"}, W'(frm_valid), W'(0));
    check({tag, "_data"}, frm_data, W'(0));
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_count"}, W'(frames_sent), W'(0));
    check({tag, "_err"}, W'(err_timeout), W'(0));
  endtask

  initial begin
    RESET     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    frm_ready = 1'b0;
    frm_done  = 1'b0;
    cur       = '0;
    ptr       = 0;
    frames    = 0;
    err       = 1'b0;
    exp_frame = '0;
    w         = 0;
    for (int i = 0; i < NREQ; i++) pay[i] = '0;

    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RESET = 1'b1;

`ifdef LINK_IDLE_FRAME_EN
    for (int i = 1; i <= GAP; i++) begin
      @(negedge CLK);
      if (i == GAP - 1) check("ka_early", W'(frm_valid), W'(0));
    end
    check("ka_valid", W'(frm_valid), W'(1));
    check("ka_frame", frm_data, W'(0));
    check("ka_ready", W'(req_ready), W'(0));
    frm_ready = 1'b1;
    @(negedge CLK);
    frm_ready = 1'b0;
    frm_done  = 1'b1;
    @(negedge CLK);
    frm_done  = 1'b0;
    check("ka_count", W'(frames_sent), W'(0));
    check("ka_busy", W'(busy), W'(0));
`else
    repeat (40) @(negedge CLK);
    check("idle_valid", W'(frm_valid), W'(0));
    check("idle_busy", W'(busy), W'(0));
`endif

    // Single requester 0 with payload A5
    raise(3'b001);
    pay[0] = 192'hA5;
    drive_reqs();
    send_frame(0, 0);

    // All requesters held: strict rotation
    for (int i = 0; i < 6; i++) begin
      raise(3'b111);
      send_frame(0, 0);
    end

    // Long OFFER stall with other requesters pending
    raise(3'b111);
    send_frame(20, 2);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      raise(NREQ'($urandom_range(0, 7)));
      if (cur == '0) raise(NREQ'(1 << $urandom_range(0, NREQ - 1)));
      send_frame(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
    end

    // Missing frm_done: timeout boundary
    if (cur == '0) raise(3'b001);
    grant_phase(w);
    offer_phase(0);
    repeat (TMO - 1) @(negedge CLK);
    check("to_busy_before", W'(busy), W'(1));
    check("to_err_before", W'(err_timeout), W'(err));
    @(negedge CLK);
    err = 1'b1;
    check("to_busy", W'(busy), W'(0));
    check("to_err", W'(err_timeout), W'(1));
    check("to_count", W'(frames_sent), W'(16'(frames)));
    if (cur == '0) raise(3'b010);
    send_frame(1, 1);

    // Drain pending requesters, then reset during WAIT_DONE
    for (int i = 0; i < NREQ && cur != '0; i++) send_frame(0, 0);
    raise(3'b001);
    grant_phase(w);
    offer_phase(0);
    raise(3'b010);
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b0;
    #1 check_reset_values("midrst");
    ptr    = 0;
    frames = 0;
    err    = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    send_frame(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
